bit_serializer: RTL and testbench

Parallel-to-serial front end for the serial pattern detectors in this codebase. It accepts WIDTH-bit words through a valid/ready handshake and emits them one bit per clock on dout, with dout_valid qualifying each bit. dout feeds a detector's serial input directly. Back-to-back words stream with no gap cycle, so patterns that span word boundaries stay contiguous for overlapping detection.

---
 rtl/bit_serializer_if.sv | 23 ++
 rtl/bit_serializer.sv | 95 +++++++++
 tb/tb_bit_serializer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bus for bit_serializer: handshake input side plus the registered serial outputs.
interface bit_serializer_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             en;
  logic             dout;
  logic             dout_valid;
  logic             last;
  logic             busy;

  modport master (
    output din, din_valid, en,
    input  din_ready, dout, dout_valid, last, busy
  );

  modport slave (
    input  din, din_valid, en,
    output din_ready, dout, dout_valid, last, busy
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: WIDTH-bit words in via valid/ready, one registered bit per enabled clock out,
// with back-to-back words streamed without a gap so boundary-spanning patterns stay contiguous.
module bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  bit_serializer_if.slave   bus
);
  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             last_q, last_d;
  logic             ready;
  logic             accept;

  // sreg holds the bit currently on dout at its head plus all bits still to come.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign ready  = bus.en && !rst &&
                  (state_q == IDLE || (state_q == SHIFT && cnt_q == LAST_CNT));
  assign accept = bus.din_valid && ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sreg_d       = sreg_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    last_d       = last_q;
    if (accept) begin
      // Taking a word on the final bit of the previous one keeps the stream bubble-free.
      state_d      = SHIFT;
      cnt_d        = '0;
      sreg_d       = bus.din;
      dout_d       = head_bit(bus.din);
      dout_valid_d = 1'b1;
      last_d       = 1'b0;
    end else if (bus.en && state_q == SHIFT) begin
      if (cnt_q == LAST_CNT) begin
        state_d      = IDLE;
        cnt_d        = '0;
        sreg_d       = '0;
        dout_d       = IDLE_BIT;
        dout_valid_d = 1'b0;
        last_d       = 1'b0;
      end else begin
        cnt_d        = cnt_q + CW'(1);
        sreg_d       = advance(sreg_q);
        dout_d       = head_bit(advance(sreg_q));
        dout_valid_d = 1'b1;
        last_d       = (cnt_q + CW'(1)) == LAST_CNT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sreg_q       <= '0;
      dout_q       <= IDLE_BIT;
      dout_valid_q <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sreg_q       <= sreg_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      last_q       <= last_d;
    end
  end

  assign bus.din_ready  = ready;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.last       = last_q;
  assign bus.busy       = (state_q == SHIFT);
endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share stimulus and are checked each cycle
// against a queue-of-pending-bits model, plus directed literal sequences.
module tb_bit_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         en = 1'b1;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model: each queue holds the bit on dout now followed by every bit still owed.
  bit qm[$];
  bit ql[$];
  bit acc;
  // Bits seen by a downstream consumer (dout_valid && en).
  bit cap_m[$];
  bit cap_l[$];
  int last_m = 0;

  bit_serializer_if #(.WIDTH(W)) ifm ();
  bit_serializer_if #(.WIDTH(W)) ifl ();

  assign ifm.din = din;  assign ifm.din_valid = din_valid;  assign ifm.en = en;
  assign ifl.din = din;  assign ifl.din_valid = din_valid;  assign ifl.en = en;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (.clk(clk), .rst(rst), .bus(ifm));
  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(ifl));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout t=%0t", nm, $time);
  endtask

  always @(posedge clk) begin
    acc = din_valid && en && !rst && (qm.size() <= 1);
    if (rst) begin
      qm.delete();
      ql.delete();
    end else if (en) begin
      if (qm.size() > 0) void'(qm.pop_front());
      if (ql.size() > 0) void'(ql.pop_front());
      if (acc)
        for (int k = 0; k < W; k++) begin
          qm.push_back(din[W-1-k]);
          ql.push_back(din[k]);
        end
    end
  end

  task automatic cmp(input string tag, input logic rdy, input logic d, input logic v,
                     input logic l, input logic b, input int sz, input bit hd);
    chk({tag, ".din_ready"},  rdy, en && !rst && sz <= 1);
    chk({tag, ".dout_valid"}, v,   sz > 0);
    chk({tag, ".dout"},       d,   (sz > 0) ? hd : 1'b0);
    chk({tag, ".last"},       l,   sz == 1);
    chk({tag, ".busy"},       b,   sz > 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("msb", ifm.din_ready, ifm.dout, ifm.dout_valid, ifm.last, ifm.busy,
          qm.size(), (qm.size() > 0) ? qm[0] : 1'b0);
      cmp("lsb", ifl.din_ready, ifl.dout, ifl.dout_valid, ifl.last, ifl.busy,
          ql.size(), (ql.size() > 0) ? ql[0] : 1'b0);
    end
    if (en && ifm.dout_valid) cap_m.push_back(ifm.dout);
    if (en && ifl.dout_valid) cap_l.push_back(ifl.dout);
    if (en && ifm.last) last_m++;
  end

  function automatic logic [31:0] pack(input bit q[$]);
    logic [31:0] v = '0;
    foreach (q[i]) v = {v[30:0], q[i]};
    return v;
  endfunction

  function automatic int count_1101(input bit q[$]);
    int n = 0;
    for (int i = 0; i + 3 < q.size(); i++)
      if (q[i] && q[i+1] && !q[i+2] && q[i+3]) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap_m.delete();
    cap_l.delete();
    last_m = 0;
  endtask

  // Offer a word and return one step after the edge that accepts it.
  task automatic send(input logic [W-1:0] w);
    bit ok = 1'b0;
    din = w;
    din_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifm.din_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("send");
    tick();
    din_valid = 1'b0;
    din = W'($urandom);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!ifm.busy && !ifl.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("wait_idle");
    tick();
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b1; din = 8'hA5; en = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    @(negedge clk);
    chk("rst.din_ready",  ifm.din_ready, 1'b0);
    chk("rst.dout",       ifm.dout, 1'b0);
    chk("rst.dout_valid", ifm.dout_valid, 1'b0);
    chk("rst.busy",       ifm.busy, 1'b0);
    tick();
    rst = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    chk("rel.din_ready", ifm.din_ready, 1'b1);
    tick();

    clear_cap();
    send(8'hD0);
    wait_idle();
    chk("single.bits",  pack(cap_m), 32'h0000_00D0);
    chk("single.count", cap_m.size(), 8);
    chk("single.last",  last_m, 1);

    clear_cap();
    send(8'hDD);
    send(8'hDD);
    wait_idle();
    chk("b2b.bits",   pack(cap_m), 32'h0000_DDDD);
    chk("b2b.count",  cap_m.size(), 16);
    chk("b2b.detect", count_1101(cap_m), 4);

    clear_cap();
    send(8'hB4);
    tick();
    tick();
    en = 1'b0;
    @(negedge clk);
    chk("stall.dout",  ifm.dout, 1'b1);
    chk("stall.valid", ifm.dout_valid, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    en = 1'b1;
    wait_idle();
    chk("stall.bits",  pack(cap_m), 32'h0000_00B4);
    chk("stall.count", cap_m.size(), 8);

    clear_cap();
    send(8'h0B);
    wait_idle();
    chk("lsb.bits", pack(cap_l), 32'h0000_00D0);
    chk("msb.0b",   pack(cap_m), 32'h0000_000B);

    clear_cap();
    send(8'hFF);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.valid", ifm.dout_valid, 1'b0);
    chk("midrst.busy",  ifm.busy, 1'b0);
    tick();
    send(8'h80);
    wait_idle();
    chk("midrst.bits",  pack(cap_m), 32'h0000_0F80);
    chk("midrst.count", cap_m.size(), 12);

    repeat (800) begin
      din       = W'($urandom);
      din_valid = ($urandom_range(0, 9) < 7);
      en        = ($urandom_range(0, 9) < 8);
      rst       = ($urandom_range(0, 99) < 2);
      tick();
    end
    rst = 1'b0; din_valid = 1'b0; en = 1'b1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
